// File: rtl/seq_detect_ctrl.sv
// Purpose : programmable serial pattern detector; words arrive over valid/ready and are shifted MSB-first into a match engine.
// Latency : word accepted in cycle T, bit k enters history at end of T+1+k, match_pulse for bit k in cycle T+2+k.
// Backpr. : in_ready only in WAIT, so one word per DATA_W+1 cycles; optional non-overlap mode via SEQ_DETECT_CTRL_NONOVL_EN.
module seq_detect_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic [CNT_W-1:0]   thresh,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               busy,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               irq,
  input  logic               irq_clr
`ifdef SEQ_DETECT_CTRL_NONOVL_EN
  ,
  input  logic               cfg_nonovl
`endif
);

  localparam int          IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [3:0]  PAT_MAX_L = 4'(PAT_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Configuration registers (only writable while idle).
  logic [PAT_MAX-1:0] cfg_pattern_q;
  logic [3:0]         cfg_len_q;
  logic [3:0]         cfg_len_clamped;

  // Shift engine.
  logic [DATA_W-1:0]  shbuf_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic [PAT_MAX-1:0] history_q;
  logic [3:0]         bits_seen_q;
  logic               stop_pend_q, stop_pend_d;

  // FSM strobes.
  logic accept;
  logic shift_en;
  logic run_clear;
  logic busy_c;
  logic ready_c;

  // Match datapath.
  logic               shift_bit;
  logic [PAT_MAX-1:0] hist_shift;
  logic [3:0]         seen_shift;
  logic [PAT_MAX-1:0] pat_mask;
  logic               match_d;
  logic               nonovl_clr;

  // Counter / interrupt.
  logic               cnt_sat;
  logic               cnt_inc;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               irq_set;

  assign in_ready = ready_c;
  assign busy     = busy_c;

  // Out-of-range lengths (0 or above PAT_MAX) fall back to the longest pattern.
  assign cfg_len_clamped = ((cfg_len == 4'd0) || (cfg_len > PAT_MAX_L)) ? PAT_MAX_L : cfg_len;

  // Capture configuration while no run is active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_pattern_q <= '0;
      cfg_len_q     <= 4'd1;
    end else if (cfg_we && !busy_c) begin
      cfg_pattern_q <= cfg_pattern;
      cfg_len_q     <= cfg_len_clamped;
    end
  end

`ifdef SEQ_DETECT_CTRL_NONOVL_EN
  logic cfg_nonovl_q;

  // Non-overlap mode flag, captured alongside the rest of the config.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_nonovl_q <= 1'b0;
    end else if (cfg_we && !busy_c) begin
      cfg_nonovl_q <= cfg_nonovl;
    end
  end

  // In non-overlap mode a registered match restarts the search from scratch.
  assign nonovl_clr = cfg_nonovl_q && match_d;
`else
  assign nonovl_clr = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Next-state and control strobes; stop beats a same-cycle word in WAIT.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    shift_en  = 1'b0;
    run_clear = 1'b0;
    busy_c    = 1'b0;
    ready_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_WAIT;
          run_clear = 1'b1;
        end
      end
      ST_WAIT: begin
        busy_c  = 1'b1;
        ready_c = 1'b1;
        if (stop || stop_pend_q) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy_c   = 1'b1;
        shift_en = 1'b1;
        if (bit_idx_q == '0) begin
          state_d = (stop || stop_pend_q) ? ST_IDLE : ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A stop seen mid-word is remembered until the word has fully shifted out.
  assign stop_pend_d = (state_q == ST_SHIFT) && (state_d == ST_SHIFT) && (stop || stop_pend_q);

  // Word buffer and bit pointer; the pointer walks from MSB down to bit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shbuf_q   <= '0;
      bit_idx_q <= '0;
    end else if (accept) begin
      shbuf_q   <= in_data;
      bit_idx_q <= IDX_LAST;
    end else if (shift_en && (bit_idx_q != '0)) begin
      bit_idx_q <= bit_idx_q - 1'b1;
    end
  end

  assign shift_bit  = shbuf_q[bit_idx_q];
  assign hist_shift = {history_q[PAT_MAX-2:0], shift_bit};
  assign seen_shift = (bits_seen_q >= PAT_MAX_L) ? PAT_MAX_L : (bits_seen_q + 4'd1);
  assign pat_mask   = ~({PAT_MAX{1'b1}} << cfg_len_q);

  // Match is judged on the history as it will be after this cycle's shift,
  // so registering it lands the pulse one cycle after the bit enters history.
  assign match_d = shift_en
                && (((hist_shift ^ cfg_pattern_q) & pat_mask) == '0)
                && (seen_shift >= cfg_len_q);

  // History and bits-seen persist across words; cleared at run start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      history_q   <= '0;
      bits_seen_q <= '0;
    end else if (run_clear) begin
      history_q   <= '0;
      bits_seen_q <= '0;
    end else if (shift_en) begin
      if (nonovl_clr) begin
        history_q   <= '0;
        bits_seen_q <= '0;
      end else begin
        history_q   <= hist_shift;
        bits_seen_q <= seen_shift;
      end
    end
  end

  // Registered match strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= match_d;
    end
  end

  assign cnt_sat = &match_cnt;
  assign cnt_inc = match_pulse && !cnt_sat;
  assign cnt_nxt = match_cnt + CNT_W'(1);

  // Saturating match counter; a run start takes priority over a late pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_cnt <= '0;
    end else if (run_clear) begin
      match_cnt <= '0;
    end else if (cnt_inc) begin
      match_cnt <= cnt_nxt;
    end
  end

  // irq fires only on the count actually stepping onto the threshold.
  assign irq_set = cnt_inc && !run_clear && (thresh != '0) && (cnt_nxt == thresh);

  // Sticky interrupt; a same-cycle set overrides the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (irq_set) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Controller and sequencer for a programmable serial pattern detector: accepts parallel words over a valid/ready handshake and shifts them MSB-first, one bit per cycle, into an internal match engine.
- Pattern and length are run-time configurable. Matches may overlap.
- Counts matches, raises a sticky interrupt at a programmable threshold, and handles run start and stop at word boundaries.

Parameters:
- DATA_W, 8, input word width; bits shifted per accepted word.
- PAT_MAX, 8, maximum pattern length in bits (2..15).
- CNT_W, 8, match counter and threshold width.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config write strobe; ignored while busy=1.
- cfg_pattern  in  PAT_MAX  pattern; bit 0 is the most recent bit; only the low cfg_len bits are used.
- cfg_len  in  4  pattern length; legal range 1..PAT_MAX.
- thresh  in  CNT_W  interrupt threshold; 0 disables the interrupt.
- start  in  1  pulse: begin a run.
- stop  in  1  pulse: end the run at the next word boundary.
- in_valid  in  1  word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  DATA_W  word; bit DATA_W-1 is shifted first.
- busy  out  1  run active.
- match_pulse  out  1  one-cycle pulse per detected match.
- match_cnt  out  CNT_W  saturating match count.
- irq  out  1  sticky threshold interrupt.
- irq_clr  in  1  clears irq.

Behaviour:
- Reset: asynchronous, active-low. Applies in any state, including mid-word.
  - State → IDLE.
  - Outputs in_ready, busy, match_pulse, match_cnt and irq all 0.
  - History, bits_seen, cfg_pattern_q = 0; cfg_len_q = 1.
- Config capture: on cfg_we with busy=0, register cfg_pattern and cfg_len. cfg_len values of 0 or greater than PAT_MAX are clamped to PAT_MAX.
- FSM states:
  - IDLE:
    - busy=0, in_ready=0.
    - start → WAIT. On this transition clear history, bits_seen and match_cnt. irq is not cleared.
  - WAIT:
    - busy=1, in_ready=1.
    - stop (or a stop pending from SHIFT) → IDLE.
    - in_valid&in_ready → latch in_data into the shift buffer, set bit_idx=DATA_W-1, go to SHIFT.
    - If stop and in_valid occur in the same cycle, stop wins and no word is accepted.
  - SHIFT:
    - busy=1, in_ready=0.
    - Each cycle shift buffer[bit_idx] into history bit 0 (older bits move up) and increment bits_seen, saturating at PAT_MAX.
    - After bit 0 is shifted: go to WAIT, or to IDLE if a stop is pending.
    - A stop seen in SHIFT is latched as pending; the current word always completes.
- Handshake: a word is accepted in cycle T. Bit k (MSB = 0) enters history at the end of cycle T+1+k. The next word can be accepted at T+DATA_W+1 (one bubble cycle per word).
- Match:
  - Combinational: history[cfg_len_q-1:0] == cfg_pattern_q[cfg_len_q-1:0] and bits_seen >= cfg_len_q.
  - Registered: match_pulse is high in the cycle after the matching bit is shifted, i.e. T+2+k for bit k.
  - Overlapping matches are allowed: history is not cleared on a match.
  - History persists across word boundaries within a run.
- Counter: match_cnt increments on each match_pulse and saturates at 2^CNT_W-1 (no wrap).
- Interrupt:
  - irq sets when thresh != 0 and match_cnt transitions to a value equal to thresh.
  - irq stays set until irq_clr. If irq_clr and the set condition occur in the same cycle, set wins.
- start in WAIT or SHIFT is ignored.
- The last word's final match_pulse may fire in the first cycle of IDLE.

Optional Feature:
- Macro: SEQ_DETECT_CTRL_NONOVL_EN.
- Defined:
  - Adds input port cfg_nonovl (1 bit), captured on cfg_we together with the other config.
  - When cfg_nonovl=1, history and bits_seen clear in the same cycle a match is registered, so a new match needs cfg_len fresh bits.
  - When cfg_nonovl=0, behaviour is identical to the macro being undefined.
- Undefined: no extra port; matching is always overlapping.

Test Plan:
- Overlap match: reset, cfg pattern=5'b11011, len=5, start, send 0xDB → match_pulse at T+6 and T+9, match_cnt=2, in_ready returns at T+9.
- Cross-word match: same config, send 0x06 then 0xC0 → exactly one match, on the 2nd bit of the second word; match_cnt=1.
- Interrupt: thresh=3, send 0xDB, 0xDB → irq sets when match_cnt reaches 3 and stays set. Then irq_clr → irq=0; a further match gives match_cnt=5 and irq stays 0.
- Stop at boundary: assert stop during SHIFT of the first word → word finishes, FSM goes to IDLE, busy=0, second in_valid is never accepted. cfg_we while busy is ignored (len unchanged).
- Mid-word reset: drive reset_n low at T+4 → all outputs 0 immediately; after release, start gives match_cnt=0 and no match until 5 new bits are shifted.
- With SEQ_DETECT_CTRL_NONOVL_EN and cfg_nonovl=1, send 0xDB → only one match (bit 4); match_cnt=1.
